// File: rtl/id_ex_issue_reg.sv
// ---------------------------------------------------------------------------
// id_ex_issue_reg
//   Per-lane ID->EX issue register. It holds one decoded instruction and
//   presents the final ALU operands to the EX stage.
//   - Forwarding from EX/MEM and MEM/WB is applied combinationally to the
//     held operands. EX/MEM takes priority, and x0 is never forwarded.
//   - A load in MEM that writes a source register of the held instruction
//     raises a load-use hazard. The hazard withholds ex_valid for one cycle.
//   - While the instruction is stalled, the captured rs1/rs2 data is
//     rewritten with the forwarded values every cycle. A producer's result
//     is therefore kept after that producer has drained past WB.
//
// Parameters: XLEN (datapath width), RA_W (register index width)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard held instruction, block capture
//   id_valid/id_ready        ID handshake
//   id_*                     decoded instruction fields from ID
//   exm_*                    instruction currently in MEM (forward/hazard)
//   mwb_*                    instruction currently in WB (forward)
//   ex_valid/ex_ready        EX handshake
//   alu_op, alu_op_chosen    funct3 and sub/sra select for the ALU
//   alu_in1, alu_in2         ALU operands
//   ex_store_data            forwarded rs2 for stores
//   ex_pc, ex_rd, ex_reg_we, ex_is_load   sideband carried into EX
// Optional build macro ID_EX_PERF_CNT_EN adds two outputs:
//   perf_hazard_cnt          cycles with a load-use hazard
//   perf_stall_cnt           cycles with ex_valid & ~ex_ready
// ---------------------------------------------------------------------------
module id_ex_issue_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    // ID side
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1_idx,
    input  logic [RA_W-1:0] id_rs2_idx,
    input  logic [RA_W-1:0] id_rd_idx,
    input  logic            id_rs1_en,
    input  logic            id_rs2_en,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [2:0]      id_func3,
    input  logic            id_func7b5,
    input  logic            id_is_rtype,
    input  logic            id_src1_pc,
    input  logic            id_src2_imm,
    input  logic            id_reg_we,
    input  logic            id_is_load,
    // MEM stage
    input  logic            exm_valid,
    input  logic            exm_we,
    input  logic            exm_is_load,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    // WB stage
    input  logic            mwb_valid,
    input  logic            mwb_we,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    // EX side
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [2:0]      alu_op,
    output logic            alu_op_chosen,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_we,
`ifdef ID_EX_PERF_CNT_EN
    output logic            ex_is_load,
    output logic [31:0]     perf_hazard_cnt,
    output logic [31:0]     perf_stall_cnt
`else
    output logic            ex_is_load
`endif
);

    // Held instruction state
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1_idx;
        logic [RA_W-1:0] rs2_idx;
        logic [RA_W-1:0] rd;
        logic            rs1_en;
        logic            rs2_en;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [2:0]      func3;
        logic            op_chosen;
        logic            src1_pc;
        logic            src2_imm;
        logic            reg_we;
        logic            is_load;
    } issue_t;

    issue_t          iss_q;
    logic            vld_q;

    logic [XLEN-1:0] fwd1, fwd2;
    logic            hazard;
    logic            fire;
    logic            load;
    logic            dec_chosen;

    // ---------------- forwarding ----------------
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] idx,
        input logic [XLEN-1:0] held
    );
        logic [XLEN-1:0] r;
        r = held;
        if (idx != '0) begin
            if (exm_valid && exm_we && (exm_rd == idx))
                r = exm_result;
            else if (mwb_valid && mwb_we && (mwb_rd == idx))
                r = mwb_data;
        end
        return r;
    endfunction

    assign fwd1 = fwd_sel(iss_q.rs1_idx, iss_q.rs1_data);
    assign fwd2 = fwd_sel(iss_q.rs2_idx, iss_q.rs2_data);

    // A load in MEM has no data yet. Stall one cycle so that the value
    // arrives through MEM/WB forwarding.
    assign hazard = vld_q & exm_valid & exm_we & exm_is_load & (exm_rd != '0) &
                    ((iss_q.rs1_en & (exm_rd == iss_q.rs1_idx)) |
                     (iss_q.rs2_en & (exm_rd == iss_q.rs2_idx)));

    // ---------------- handshake ----------------
    assign ex_valid = vld_q & ~hazard;
    assign fire     = ex_valid & ex_ready;
    assign id_ready = ~flush & (~vld_q | fire);
    assign load     = id_valid & id_ready;

    // sub/sra select: R-type uses instr[30] directly. For immediates,
    // instr[30] is an opcode bit only for srai. For other I-types it is
    // part of the immediate.
    assign dec_chosen = id_is_rtype ? id_func7b5
                                    : ((id_func3 == 3'b101) & id_func7b5);

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            iss_q <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (load) begin
            vld_q          <= 1'b1;
            iss_q.pc       <= id_pc;
            iss_q.rs1_idx  <= id_rs1_idx;
            iss_q.rs2_idx  <= id_rs2_idx;
            iss_q.rd       <= id_rd_idx;
            iss_q.rs1_en   <= id_rs1_en;
            iss_q.rs2_en   <= id_rs2_en;
            iss_q.rs1_data <= id_rs1_data;
            iss_q.rs2_data <= id_rs2_data;
            iss_q.imm      <= id_imm;
            iss_q.func3    <= id_func3;
            iss_q.op_chosen <= dec_chosen;
            iss_q.src1_pc  <= id_src1_pc;
            iss_q.src2_imm <= id_src2_imm;
            iss_q.reg_we   <= id_reg_we;
            iss_q.is_load  <= id_is_load;
        end else if (fire) begin
            vld_q <= 1'b0;
        end else if (vld_q) begin
            // Stalled: keep whatever forwarding currently supplies so the
            // operand is still correct after the producer leaves WB.
            iss_q.rs1_data <= fwd1;
            iss_q.rs2_data <= fwd2;
        end
    end

    // ---------------- outputs ----------------
    assign alu_op        = iss_q.func3;
    assign alu_op_chosen = iss_q.op_chosen;
    assign alu_in1       = iss_q.src1_pc  ? iss_q.pc  : fwd1;
    assign alu_in2       = iss_q.src2_imm ? iss_q.imm : fwd2;
    assign ex_store_data = fwd2;
    assign ex_pc         = iss_q.pc;
    assign ex_rd         = iss_q.rd;
    assign ex_reg_we     = iss_q.reg_we;
    assign ex_is_load    = iss_q.is_load;

`ifdef ID_EX_PERF_CNT_EN
    // Free-running; flush does not affect these counters. They wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hazard_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (hazard)
                perf_hazard_cnt <= perf_hazard_cnt + 32'd1;
            if (ex_valid && !ex_ready)
                perf_stall_cnt  <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_issue_reg.sv
module tb_id_ex_issue_reg;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic            id_valid, id_ready;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0] id_rs1_idx, id_rs2_idx, id_rd_idx;
    logic            id_rs1_en, id_rs2_en;
    logic [2:0]      id_func3;
    logic            id_func7b5, id_is_rtype, id_src1_pc, id_src2_imm;
    logic            id_reg_we, id_is_load;
    logic            exm_valid, exm_we, exm_is_load;
    logic [RA_W-1:0] exm_rd;
    logic [XLEN-1:0] exm_result;
    logic            mwb_valid, mwb_we;
    logic [RA_W-1:0] mwb_rd;
    logic [XLEN-1:0] mwb_data;
    logic            ex_valid, ex_ready;
    logic [2:0]      alu_op;
    logic            alu_op_chosen;
    logic [XLEN-1:0] alu_in1, alu_in2, ex_store_data, ex_pc;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_we, ex_is_load;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_issue_reg #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .id_rd_idx(id_rd_idx),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_func3(id_func3), .id_func7b5(id_func7b5), .id_is_rtype(id_is_rtype),
        .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
        .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .exm_valid(exm_valid), .exm_we(exm_we), .exm_is_load(exm_is_load),
        .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_valid(mwb_valid), .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_op(alu_op), .alu_op_chosen(alu_op_chosen),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic e1, input logic e2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [2:0] f3, input logic f7, input logic rt,
                         input logic s1pc, input logic s2imm);
        id_valid = 1'b1; id_pc = pc; id_rs1_idx = r1; id_rs2_idx = r2; id_rd_idx = rd;
        id_rs1_en = e1; id_rs2_en = e2; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_func3 = f3; id_func7b5 = f7; id_is_rtype = rt; id_src1_pc = s1pc;
        id_src2_imm = s2imm; id_reg_we = 1'b1; id_is_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_pc = '0;
        id_rs1_idx = '0; id_rs2_idx = '0; id_rd_idx = '0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_func3 = '0; id_func7b5 = 1'b0;
        id_is_rtype = 1'b0; id_src1_pc = 1'b0; id_src2_imm = 1'b0; id_reg_we = 1'b0;
        id_is_load = 1'b0; exm_valid = 1'b0; exm_we = 1'b0; exm_is_load = 1'b0;
        exm_rd = '0; exm_result = '0; mwb_valid = 1'b0; mwb_we = 1'b0; mwb_rd = '0;
        mwb_data = '0; ex_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        // reset state
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_in2", alu_in2, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);

        // add x3,x1,x2 with rs1=5, rs2=7
        offer(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd5, 32'd7, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("add_id_ready_pre", 32'(id_ready), 32'd1);
        tick(); id_valid = 1'b0; #1;
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'd0);
        chk("add_chosen", 32'(alu_op_chosen), 32'd0);
        chk("add_in1", alu_in1, 32'd5);
        chk("add_in2", alu_in2, 32'd7);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_id_ready", 32'(id_ready), 32'd1);
        tick();
        chk("add_drained", 32'(ex_valid), 32'd0);

        // sub x4,x1,x2 held with forwarding priority
        ex_ready = 1'b0;
        offer(32'h200, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 32'd1, 32'd2, 32'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); id_valid = 1'b0;
        exm_valid = 1'b1; exm_we = 1'b1; exm_rd = 5'd1; exm_result = 32'h10;
        mwb_valid = 1'b1; mwb_we = 1'b1; mwb_rd = 5'd1; mwb_data = 32'h20;
        #1;
        chk("sub_chosen", 32'(alu_op_chosen), 32'd1);
        chk("fwd_exm_prio", alu_in1, 32'h10);
        chk("sub_hold_id_ready", 32'(id_ready), 32'd0);
        exm_rd = 5'd0; #1;
        chk("fwd_mwb", alu_in1, 32'h20);
        mwb_rd = 5'd0; #1;
        chk("fwd_x0_raw", alu_in1, 32'd1);
        chk("fwd_in2_raw", alu_in2, 32'd2);
        exm_valid = 1'b0; exm_we = 1'b0; mwb_valid = 1'b0; mwb_we = 1'b0;
        ex_ready = 1'b1;
        tick();
        chk("sub_drained", 32'(ex_valid), 32'd0);

        // load-use: lw x5 in MEM, held add uses x5
        offer(32'h300, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h1111, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); id_valid = 1'b0;
        exm_valid = 1'b1; exm_we = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd5; exm_result = 32'hDEAD;
        #1;
        chk("lu_ex_valid", 32'(ex_valid), 32'd0);
        chk("lu_id_ready", 32'(id_ready), 32'd0);
        tick();
        exm_valid = 1'b0; exm_we = 1'b0; exm_is_load = 1'b0; exm_rd = 5'd0;
        mwb_valid = 1'b1; mwb_we = 1'b1; mwb_rd = 5'd5; mwb_data = 32'hABCD;
        #1;
        chk("lu_ex_valid_after", 32'(ex_valid), 32'd1);
        chk("lu_fwd_in1", alu_in1, 32'hABCD);
        chk("lu_id_ready_after", 32'(id_ready), 32'd1);
        tick();
        mwb_valid = 1'b0; mwb_we = 1'b0; mwb_rd = 5'd0;
        #1 chk("lu_drained", 32'(ex_valid), 32'd0);

        // 3-cycle stall with a one-cycle mwb producer of rs2
        ex_ready = 1'b0;
        offer(32'h400, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'd9, 32'd3, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        // srai x8,x1,5 waits in ID during the stall
        offer(32'h500, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 32'd9, 32'd0, 32'h405, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
        mwb_valid = 1'b1; mwb_we = 1'b1; mwb_rd = 5'd2; mwb_data = 32'h55;
        #1;
        chk("stall_in2_c1", alu_in2, 32'h55);
        chk("stall_id_ready", 32'(id_ready), 32'd0);
        tick();
        mwb_valid = 1'b0; mwb_we = 1'b0; mwb_rd = 5'd0; mwb_data = 32'h0;
        #1;
        chk("stall_in2_c2", alu_in2, 32'h55);
        chk("stall_no_capture", ex_pc, 32'h400);
        tick();
        chk("stall_store_data", ex_store_data, 32'h55);
        ex_ready = 1'b1; #1;
        chk("release_in2", alu_in2, 32'h55);
        chk("release_id_ready", 32'(id_ready), 32'd1);
        tick(); id_valid = 1'b0; #1;
        // srai captured back-to-back
        chk("srai_ex_valid", 32'(ex_valid), 32'd1);
        chk("srai_pc", ex_pc, 32'h500);
        chk("srai_op", 32'(alu_op), 32'd5);
        chk("srai_chosen", 32'(alu_op_chosen), 32'd1);
        chk("srai_in2_imm", alu_in2, 32'h405);
        // addi with imm[30] set (instr[30]=1)
        offer(32'h600, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 32'd4, 32'd0, 32'h40000001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); id_valid = 1'b0; #1;
        chk("addi_pc", ex_pc, 32'h600);
        chk("addi_chosen", 32'(alu_op_chosen), 32'd0);
        chk("addi_in2", alu_in2, 32'h40000001);
        tick();

        // flush with incoming valid and held instruction
        ex_ready = 1'b0;
        offer(32'h700, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd1, 32'd1, 32'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        offer(32'h800, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd1, 32'd1, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1; #1;
        chk("flush_id_ready", 32'(id_ready), 32'd0);
        chk("flush_pre_in1_pc", alu_in1, 32'h700);
        tick(); flush = 1'b0; id_valid = 1'b0; #1;
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_not_captured", ex_pc, 32'h700);
        chk("flush_id_ready_after", 32'(id_ready), 32'd1);

        // reset mid-operation
        offer(32'h900, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'hAA, 32'hBB, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); id_valid = 1'b0; #1;
        chk("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("midrst_in1", alu_in1, 32'd0);
        chk("midrst_pc", ex_pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_issue_reg.md
Name: id_ex_issue_reg

Overview:
- Per-lane ID→EX pipeline register that directly feeds the EX-stage ALU: produces alu_op, alu_op_chosen, alu_in1, alu_in2.
- Resolves EX/MEM and MEM/WB forwarding at its output and detects load-use hazards.
- Holds the instruction under back-pressure and refreshes captured operands while held, so stale register-file data never reaches the ALU.
- Instantiated once per issue lane.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill held instruction (branch mispredict/trap)
id_valid  in  1  ID offers instruction
id_ready  out  1  register accepts this cycle
id_pc  in  XLEN  instruction PC
id_rs1_idx, id_rs2_idx, id_rd_idx  in  RA_W  register indices
id_rs1_en, id_rs2_en  in  1  operand actually read
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_func3  in  3  funct3
id_func7b5  in  1  instr[30]
id_is_rtype  in  1  OP (vs OP-IMM/other)
id_src1_pc  in  1  alu_in1 = PC
id_src2_imm  in  1  alu_in2 = imm
id_reg_we, id_is_load  in  1  writeback / load flags
exm_valid, exm_we, exm_is_load  in  1  instruction now in MEM
exm_rd  in  RA_W
exm_result  in  XLEN  EX result of MEM-stage instruction
mwb_valid, mwb_we  in  1  instruction now in WB
mwb_rd  in  RA_W
mwb_data  in  XLEN  writeback data
ex_valid  out  1  ALU inputs valid
ex_ready  in  1  EX accepts
alu_op  out  3  funct3 to ALU
alu_op_chosen  out  1  sub/sra select
alu_in1, alu_in2  out  XLEN  ALU operands
ex_store_data  out  XLEN  forwarded rs2
ex_pc  out  XLEN
ex_rd  out  RA_W
ex_reg_we, ex_is_load  out  1

Behaviour:
- Reset: vld_q=0; all held fields 0. So ex_valid=0, id_ready=1, and the alu_* outputs and ex_* data outputs are 0.
- Capture-time decode:
  - R-type: alu_op_chosen=func7b5.
  - I-type: alu_op_chosen=func7b5 only if func3=3'b101 (srai); otherwise 0.
- Forwarding (combinational on held fields), per operand: fwd = held rs data, with override:
  - exm_valid&exm_we&exm_rd==idx&idx!=0 → exm_result;
  - else mwb_valid&mwb_we&mwb_rd==idx&idx!=0 → mwb_data.
  - EX/MEM has priority. x0 never forwarded.
- Operand select: alu_in1 = src1_pc ? pc : fwd1; alu_in2 = src2_imm ? imm : fwd2; ex_store_data = fwd2.
- hazard = vld_q & exm_valid & exm_we & exm_is_load & exm_rd!=0 & ((rs1_en & exm_rd==rs1_idx) | (rs2_en & exm_rd==rs2_idx)).
- Handshake:
  - ex_valid = vld_q & ~hazard.
  - fire = ex_valid & ex_ready.
  - id_ready = ~flush & (~vld_q | fire).
  - load = id_valid & id_ready.
- Next state:
  - flush → vld_q=0. Highest priority; no load that cycle.
  - load → capture all id_* fields, vld_q=1. Zero-bubble back-to-back when fire.
  - fire & ~load → vld_q=0.
  - Otherwise hold. While holding (vld_q & ~fire), rs1/rs2 data registers are rewritten with fwd1/fwd2 each cycle. Producer values are thus preserved after they leave MEM/WB.
- Latency: one cycle ID→EX when there is no hazard. A load-use hazard inserts exactly one bubble: the next cycle the load is in WB and is forwarded via mwb.
- id_valid with id_ready=0: ID must hold its inputs stable; nothing is captured.
- Reset asserted mid-operation: the held instruction is discarded the next cycle.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs perf_hazard_cnt[31:0] (cycles with hazard=1) and perf_stall_cnt[31:0] (cycles with ex_valid & ~ex_ready). Both counters are zeroed by rst, wrap modulo 2^32, and are unaffected by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then id_valid=1 with add x3,x1,x2 (rs1=5, rs2=7, no producers), ex_ready=1 → next cycle ex_valid=1, alu_op=000, alu_op_chosen=0, alu_in1=5, alu_in2=7; id_ready stays 1 throughout.
- Held sub rs1=x1 with exm writing x1=0x10 and mwb writing x1=0x20 the same cycle → alu_in1=0x10 (EX/MEM priority); with rd=x0 on both producers → raw register-file value is used.
- lw x5 in MEM (exm_is_load=1, exm_rd=5), held add uses x5 → ex_valid=0 and id_ready=0 for 1 cycle; next cycle mwb_data=0xABCD is forwarded, alu_in1=0xABCD, fire.
- ex_ready=0 for 3 cycles while mwb writes rs2=0x55 in the first cycle only → after release, alu_in2=0x55 (operand refreshed); no new capture occurs during the stall.
- srai (func3=101, func7b5=1, id_is_rtype=0) → alu_op_chosen=1; addi with imm bit30 set → alu_op_chosen=0.
- flush together with id_valid=1 and vld_q=1 → next cycle ex_valid=0; the incoming instruction is not captured.
